// File: rtl/n64_pif_pkg.sv
// Shared definitions for the N64-side PIF serial front end: command op codes,
// FSM state encodings and transfer lengths.
package n64_pif_pkg;

  typedef enum logic [1:0] {
    OP_READ4   = 2'b00,
    OP_WRITE4  = 2'b01,
    OP_READ64  = 2'b10,
    OP_WRITE64 = 2'b11
  } pif_op_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCmd     = 3'd1,
    StWrData  = 3'd2,
    StRdFetch = 3'd3,
    StRdShift = 3'd4,
    StDone    = 3'd5
  } pif_state_e;

  localparam logic [6:0] LEN4  = 7'd4;
  localparam logic [6:0] LEN64 = 7'd64;

  // cmd[6] set means the console sends data; cmd[7] selects the 64-byte length.
  function automatic logic op_is_write(input pif_op_e op);
    return (op == OP_WRITE4) || (op == OP_WRITE64);
  endfunction

  function automatic logic [6:0] op_len(input pif_op_e op);
    return ((op == OP_READ64) || (op == OP_WRITE64)) ? LEN64 : LEN4;
  endfunction

endpackage

// File: rtl/n64_pif_sync.sv
// Synchroniser for the sampled RCP serial clock and data, with single-cycle
// rise/fall pulses derived from the synchronised clock.
module n64_pif_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic n64_clk_i,
  input  logic n64_rsp_i,
  output logic rise_o,
  output logic fall_o,
  output logic rsp_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] rsp_sync_q, rsp_sync_d;
  logic                   clk_prev_q, clk_prev_d;

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], n64_clk_i};
    rsp_sync_d = {rsp_sync_q[SYNC_STAGES-2:0], n64_rsp_i};
    clk_prev_d = clk_sync_q[SYNC_STAGES-1];
  end

  // Data line idles high, so its chain resets to ones to avoid a false start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q <= '0;
      rsp_sync_q <= '1;
      clk_prev_q <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      rsp_sync_q <= rsp_sync_d;
      clk_prev_q <= clk_prev_d;
    end
  end

  assign rise_o = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
  assign fall_o = ~clk_sync_q[SYNC_STAGES-1] & clk_prev_q;
  assign rsp_o  = rsp_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/n64_pif_serial_if.sv
// N64-side PIF serial front end: decodes RCP command frames and moves bytes
// through port B of the PIF RAM. Optional watchdog: PIF_SERIAL_TIMEOUT_EN.
module n64_pif_serial_if
  import n64_pif_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              n64_clk,
  input  logic              n64_rsp,
  output logic              n64_pif,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [7:0]        ram_data_out,
  input  logic [7:0]        ram_q,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_error,
  output logic [7:0]        last_cmd
);

  logic rise, fall, rsp_s;

  n64_pif_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i     (clk),
    .rst_i     (reset),
    .n64_clk_i (n64_clk),
    .n64_rsp_i (n64_rsp),
    .rise_o    (rise),
    .fall_o    (fall),
    .rsp_o     (rsp_s)
  );

  pif_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [6:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        last_cmd_q, last_cmd_d;
  logic [7:0]        ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;
  logic              pif_q, pif_d;
  logic              fetch_q, fetch_d;
  logic [7:0]        shift_in;

`ifdef PIF_SERIAL_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           frame_error_q, frame_error_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    ram_addr_d = ram_addr_q;
    byte_cnt_d = byte_cnt_q;
    last_cmd_d = last_cmd_q;
    ram_data_d = ram_data_q;
    ram_wren_d = 1'b0;
    pif_d      = pif_q;
    fetch_d    = fetch_q;
    shift_in   = {shift_q[6:0], rsp_s};

    unique case (state_q)
      StIdle: begin
        if (fall) pif_d = 1'b1;
        if (rise && !rsp_s) begin
          state_d   = StCmd;
          bit_cnt_d = 3'd0;
        end
      end
      StCmd: begin
        if (rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            last_cmd_d = shift_in;
            addr_d     = ADDR_W'(shift_in[5:0]);
            ram_addr_d = ADDR_W'(shift_in[5:0]);
            byte_cnt_d = op_len(pif_op_e'(shift_in[7:6]));
            fetch_d    = 1'b0;
            state_d    = op_is_write(pif_op_e'(shift_in[7:6])) ? StWrData : StRdFetch;
          end
        end
      end
      StWrData: begin
        if (rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ram_addr_d = addr_q;
            ram_data_d = shift_in;
            ram_wren_d = 1'b1;
            addr_d     = addr_q + ADDR_W'(1);
            byte_cnt_d = byte_cnt_q - 7'd1;
            if (byte_cnt_q == 7'd1) state_d = StDone;
          end
        end
      end
      StRdFetch: begin
        // ram_address already holds addr_q on entry; second cycle sees valid ram_q.
        if (!fetch_q) begin
          fetch_d = 1'b1;
        end else begin
          fetch_d   = 1'b0;
          shift_d   = ram_q;
          bit_cnt_d = 3'd0;
          state_d   = StRdShift;
        end
      end
      StRdShift: begin
        if (fall) begin
          pif_d     = shift_q[7];
          shift_d   = {shift_q[6:0], 1'b1};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            addr_d     = addr_q + ADDR_W'(1);
            ram_addr_d = addr_q + ADDR_W'(1);
            byte_cnt_d = byte_cnt_q - 7'd1;
            state_d    = (byte_cnt_q == 7'd1) ? StDone : StRdFetch;
          end
        end
      end
      StDone: begin
        if (fall) pif_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef PIF_SERIAL_TIMEOUT_EN
    wd_d          = wd_q;
    frame_error_d = 1'b0;
    if (state_q == StIdle || rise || fall) begin
      wd_d = '0;
    end else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
      wd_d          = '0;
      state_d       = StIdle;
      pif_d         = 1'b1;
      ram_wren_d    = 1'b0;
      frame_error_d = 1'b1;
    end else begin
      wd_d = wd_q + WdW'(1);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      addr_q     <= '0;
      ram_addr_q <= '0;
      byte_cnt_q <= 7'd0;
      last_cmd_q <= 8'd0;
      ram_data_q <= 8'd0;
      ram_wren_q <= 1'b0;
      pif_q      <= 1'b1;
      fetch_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      ram_addr_q <= ram_addr_d;
      byte_cnt_q <= byte_cnt_d;
      last_cmd_q <= last_cmd_d;
      ram_data_q <= ram_data_d;
      ram_wren_q <= ram_wren_d;
      pif_q      <= pif_d;
      fetch_q    <= fetch_d;
    end
  end

`ifdef PIF_SERIAL_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q          <= '0;
      frame_error_q <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign frame_error = frame_error_q;
`else
  assign frame_error = 1'b0;
`endif

  assign n64_pif      = pif_q;
  assign ram_address  = ram_addr_q;
  assign ram_wren     = ram_wren_q;
  assign ram_data_out = ram_data_q;
  assign busy         = (state_q != StIdle);
  assign frame_done   = (state_q == StDone);
  assign last_cmd     = last_cmd_q;

endmodule

// File: tb/tb_n64_pif_serial_if.sv
// Directed bench for n64_pif_serial_if with a synchronous 64-byte RAM model on port B.
module tb_n64_pif_serial_if;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       n64_clk = 1'b0;
  logic       n64_rsp = 1'b1;
  logic       n64_pif;
  logic [5:0] ram_address;
  logic       ram_wren;
  logic [7:0] ram_data_out;
  logic [7:0] ram_q = 8'd0;
  logic       busy, frame_done, frame_error;
  logic [7:0] last_cmd;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [64];
  int   wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic prev_wren = 1'b0;
  logic dbl_wr = 1'b0;

  always #5 clk = ~clk;

  n64_pif_serial_if dut (
    .clk          (clk),
    .reset        (reset),
    .n64_clk      (n64_clk),
    .n64_rsp      (n64_rsp),
    .n64_pif      (n64_pif),
    .ram_address  (ram_address),
    .ram_wren     (ram_wren),
    .ram_data_out (ram_data_out),
    .ram_q        (ram_q),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_error  (frame_error),
    .last_cmd     (last_cmd)
  );

  always @(posedge clk) begin
    ram_q <= mem[ram_address];
    if (ram_wren) begin
      mem[ram_address] <= ram_data_out;
      wr_cnt <= wr_cnt + 1;
    end
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_error) err_cnt <= err_cnt + 1;
    prev_wren <= ram_wren;
    if (ram_wren && prev_wren) dbl_wr <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One n64_clk period: data set, pif sampled just before the rise.
  task automatic pulse(input logic b, output logic o);
    n64_rsp = b;
    tick(4);
    o = n64_pif;
    n64_clk = 1'b1;
    tick(8);
    n64_clk = 1'b0;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] v);
    logic o;
    for (int i = 7; i >= 0; i--) pulse(v[i], o);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic o;
    for (int i = 7; i >= 0; i--) begin
      pulse(1'b1, o);
      v[i] = o;
    end
  endtask

  task automatic start_frame(input logic [7:0] cmd);
    logic o;
    pulse(1'b0, o);
    send_byte(cmd);
  endtask

  initial begin
    int         w0, d0, e0;
    logic [7:0] rb;
    logic       o;

    tick(5);
    check("rst_pif", {31'd0, n64_pif}, 32'd1);
    check("rst_wren", {31'd0, ram_wren}, 32'd0);
    check("rst_addr", {26'd0, ram_address}, 32'd0);
    check("rst_wdata", {24'd0, ram_data_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_err", {31'd0, frame_error}, 32'd0);
    check("rst_lastcmd", {24'd0, last_cmd}, 32'd0);
    reset = 1'b0;
    tick(5);

    // WRITE4 to 0x08
    w0 = wr_cnt; d0 = done_cnt;
    start_frame(8'h48);
    check("w4_busy", {31'd0, busy}, 32'd1);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    n64_rsp = 1'b1;
    tick(4);
    check("w4_wrcnt", wr_cnt - w0, 32'd4);
    check("w4_done", done_cnt - d0, 32'd1);
    check("w4_m08", {24'd0, mem[8'h08]}, 32'hA1);
    check("w4_m09", {24'd0, mem[8'h09]}, 32'hB2);
    check("w4_m0a", {24'd0, mem[8'h0A]}, 32'hC3);
    check("w4_m0b", {24'd0, mem[8'h0B]}, 32'hD4);
    check("w4_lastcmd", {24'd0, last_cmd}, 32'h48);
    check("w4_idle", {31'd0, busy}, 32'd0);

    // Preload 0x10..0x13 then READ4 them back
    start_frame(8'h50);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    tick(4);
    w0 = wr_cnt; d0 = done_cnt;
    start_frame(8'h10);
    read_byte(rb); check("r4_b0", {24'd0, rb}, 32'h11);
    read_byte(rb); check("r4_b1", {24'd0, rb}, 32'h22);
    read_byte(rb); check("r4_b2", {24'd0, rb}, 32'h33);
    read_byte(rb); check("r4_b3", {24'd0, rb}, 32'h44);
    pulse(1'b1, o);
    check("r4_idle_hi", {31'd0, o}, 32'd1);
    check("r4_done", done_cnt - d0, 32'd1);
    check("r4_nowrite", wr_cnt - w0, 32'd0);
    check("r4_lastcmd", {24'd0, last_cmd}, 32'h10);
    check("r4_busy", {31'd0, busy}, 32'd0);

    // WRITE64 from 0x3E wraps through 0x00
    w0 = wr_cnt; d0 = done_cnt;
    start_frame(8'hFE);
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    n64_rsp = 1'b1;
    tick(4);
    check("w64_wrcnt", wr_cnt - w0, 32'd64);
    check("w64_done", done_cnt - d0, 32'd1);
    check("w64_m3e", {24'd0, mem[6'h3E]}, 32'h00);
    check("w64_m3f", {24'd0, mem[6'h3F]}, 32'h01);
    check("w64_m00", {24'd0, mem[6'h00]}, 32'h02);
    check("w64_m08", {24'd0, mem[6'h08]}, 32'h0A);
    check("w64_m3d", {24'd0, mem[6'h3D]}, 32'h3F);
    check("w64_lastcmd", {24'd0, last_cmd}, 32'hFE);

    // Reset after second byte of a WRITE4, mid third byte
    w0 = wr_cnt;
    start_frame(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    pulse(1'b0, o); pulse(1'b1, o); pulse(1'b0, o);
    reset = 1'b1;
    #1;
    check("rmid_busy", {31'd0, busy}, 32'd0);
    check("rmid_pif", {31'd0, n64_pif}, 32'd1);
    check("rmid_wren", {31'd0, ram_wren}, 32'd0);
    tick(3);
    reset = 1'b0;
    tick(2);
    for (int i = 0; i < 16; i++) pulse(1'b1, o);
    check("rmid_wrcnt", wr_cnt - w0, 32'd2);
    check("rmid_m04", {24'd0, mem[6'h04]}, 32'h55);
    check("rmid_m05", {24'd0, mem[6'h05]}, 32'h66);
    check("rmid_m06", {24'd0, mem[6'h06]}, 32'h08);
    check("rmid_idle", {31'd0, busy}, 32'd0);

    d0 = done_cnt;
    start_frame(8'h44);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    n64_rsp = 1'b1;
    tick(4);
    check("clean_m04", {24'd0, mem[6'h04]}, 32'h01);
    check("clean_m07", {24'd0, mem[6'h07]}, 32'h04);
    check("clean_done", done_cnt - d0, 32'd1);

    // READ64 from 0x00 with n64_clk stalled partway through the second byte
    e0 = err_cnt;
    start_frame(8'h80);
    read_byte(rb);
    check("r64_b0", {24'd0, rb}, 32'h02);
    pulse(1'b1, o); pulse(1'b1, o);
    tick(5000);
`ifdef PIF_SERIAL_TIMEOUT_EN
    check("stall_err", err_cnt - e0, 32'd1);
    check("stall_busy", {31'd0, busy}, 32'd0);
    check("stall_pif", {31'd0, n64_pif}, 32'd1);
`else
    check("stall_err", err_cnt - e0, 32'd0);
    check("stall_busy", {31'd0, busy}, 32'd1);
`endif
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    check("final_busy", {31'd0, busy}, 32'd0);
    check("no_dbl_wren", {31'd0, dbl_wr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
